// File: rtl/note_sequencer.sv
// note_sequencer: steps through a song memory of {pitch, duration} words and drives
// a pwm tone generator and an external duration timer.
//
// Each note is fetched (FETCH), latched (LATCH), played until the timer reports
// completion (PLAY), and followed by GAP_CYCLES silent clocks (GAP). A word whose
// duration byte is zero marks the end of the song (END). After END the address
// returns to 0, and playback loops while play stays high.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   play       level; 1 runs the song, 0 stops it (the current note restarts on resume)
//   song_addr  song memory read address
//   song_data  memory word, valid one clock after song_addr changes; [15:8] pitch, [7:0] dur
//   pitch      latched pitch code (0 = rest)
//   note_en    pwm enable, high in PLAY for non-rest notes
//   dur        latched duration for the timer
//   dur_start  one-clock pulse on the first PLAY clock
//   dur_done   timer completion, pulse or level
//   playing    high in every state except IDLE
//   song_end   one-clock pulse in END
module note_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    output logic [ADDR_W-1:0] song_addr,
    input  logic [15:0]       song_data,
    output logic [7:0]        pitch,
    output logic              note_en,
    output logic [7:0]        dur,
    output logic              dur_start,
    input  logic              dur_done,
    output logic              playing,
    output logic              song_end
);

    localparam int unsigned GapW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StPlay,
        StGap,
        StEnd
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        pitch_q, pitch_d;
    logic [7:0]        dur_q, dur_d;
    logic [GapW-1:0]   gap_q, gap_d;
    // High only on the first PLAY clock; marks the dur_start pulse and masks dur_done.
    logic              first_q, first_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pitch_q <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pitch_q <= pitch_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pitch_d = pitch_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        first_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (play) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                pitch_d = song_data[15:8];
                dur_d   = song_data[7:0];
                if (song_data[7:0] == 8'd0) begin
                    state_d = StEnd;
                end else begin
                    state_d = StPlay;
                    first_d = 1'b1;
                end
            end
            StPlay: begin
                if (!first_q && dur_done) begin
                    if (GAP_CYCLES == 0) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StFetch;
                    end else begin
                        gap_d   = GapLoad;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q <= GapW'(1)) begin
                    gap_d   = '0;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StFetch;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StEnd: begin
                addr_d  = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stop overrides everything, including a same-clock dur_done; the address is
        // held so that resuming replays the interrupted note from its start.
        if (!play && state_q != StIdle) begin
            state_d = StIdle;
            addr_d  = addr_q;
            gap_d   = '0;
            first_d = 1'b0;
        end
    end

    assign song_addr = addr_q;
    assign pitch     = pitch_q;
    assign dur       = dur_q;
    assign playing   = (state_q != StIdle);
    assign note_en   = (state_q == StPlay) && (pitch_q != 8'd0);
    assign dur_start = (state_q == StPlay) && first_q;
    assign song_end  = (state_q == StEnd);

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench for note_sequencer.
// Main instance: ADDR_W=8, GAP_CYCLES=2, two-note song with a behavioural memory and
// duration timer. Second instance: ADDR_W=2, GAP_CYCLES=0, memory all 0x4001, to
// exercise address wrap and the no-gap path.
module tb_note_sequencer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance ----------------
    logic        reset_n, play;
    logic [7:0]  song_addr;
    logic [15:0] song_data;
    logic [7:0]  pitch, dur;
    logic        note_en, dur_start, dur_done, playing, song_end;

    logic [15:0] mem [0:255];
    always @(posedge clk) song_data <= mem[song_addr];

    // Timer model: dur_done is high on the clock dur clocks after the dur_start clock.
    logic [7:0] tcnt = 8'd0;
    logic       timer_auto, manual_done;
    always @(posedge clk) begin
        if (dur_start) tcnt <= dur;
        else if (tcnt != 8'd0) tcnt <= tcnt - 8'd1;
    end
    assign dur_done = timer_auto ? (tcnt == 8'd1) : manual_done;

    note_sequencer #(.ADDR_W(8), .GAP_CYCLES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .play      (play),
        .song_addr (song_addr),
        .song_data (song_data),
        .pitch     (pitch),
        .note_en   (note_en),
        .dur       (dur),
        .dur_start (dur_start),
        .dur_done  (dur_done),
        .playing   (playing),
        .song_end  (song_end)
    );

    // ---------------- wrap / no-gap instance ----------------
    logic        reset_n_b, play_b;
    logic [1:0]  song_addr_b;
    logic [15:0] song_data_b;
    logic [7:0]  pitch_b, dur_b;
    logic        note_en_b, dur_start_b, dur_done_b, playing_b, song_end_b;

    logic [15:0] mem_b [0:3];
    always @(posedge clk) song_data_b <= mem_b[song_addr_b];

    logic [7:0] tcnt_b = 8'd0;
    always @(posedge clk) begin
        if (dur_start_b) tcnt_b <= dur_b;
        else if (tcnt_b != 8'd0) tcnt_b <= tcnt_b - 8'd1;
    end
    assign dur_done_b = (tcnt_b == 8'd1);

    int se_b = 0;
    always @(posedge clk) if (song_end_b) se_b <= se_b + 1;

    note_sequencer #(.ADDR_W(2), .GAP_CYCLES(0)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n_b),
        .play      (play_b),
        .song_addr (song_addr_b),
        .song_data (song_data_b),
        .pitch     (pitch_b),
        .note_en   (note_en_b),
        .dur       (dur_b),
        .dur_start (dur_start_b),
        .dur_done  (dur_done_b),
        .playing   (playing_b),
        .song_end  (song_end_b)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   last_cyc;
        bit   found;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h3C0A;
        mem[1] = 16'h0005;
        mem[2] = 16'h0000;
        for (int i = 0; i < 4; i++) mem_b[i] = 16'h4001;

        reset_n = 1'b0; play = 1'b0; timer_auto = 1'b1; manual_done = 1'b0;
        reset_n_b = 1'b0; play_b = 1'b0;

        // Reset state
        step(2);
        check("rst_playing",   playing,   0);
        check("rst_addr",      song_addr, 0);
        check("rst_pitch",     pitch,     0);
        check("rst_dur",       dur,       0);
        check("rst_note_en",   note_en,   0);
        check("rst_dur_start", dur_start, 0);
        check("rst_song_end",  song_end,  0);
        reset_n = 1'b1;
        step(1);
        check("idle_no_play", playing, 0);

        // Two-note song: first note
        play = 1'b1;
        step(1);
        check("fetch_playing", playing, 1);
        check("fetch_dur_start", dur_start, 0);
        step(1);
        check("latch_dur_start", dur_start, 0);
        check("latch_note_en", note_en, 0);
        step(1);
        check("n1_dur_start", dur_start, 1);
        check("n1_dur", dur, 8'h0A);
        check("n1_pitch", pitch, 8'h3C);
        check("n1_note_en", note_en, 1);
        step(1);
        check("n1_pulse_one_clk", dur_start, 0);
        check("n1_note_en_hold", note_en, 1);
        step(9);                                   // dur_done clock t
        check("n1_last_clk_note_en", note_en, 1);
        step(1);
        check("gap1_note_en", note_en, 0);
        check("gap1_playing", playing, 1);
        check("gap1_addr", song_addr, 0);
        step(1);
        check("gap2_note_en", note_en, 0);
        check("gap2_addr", song_addr, 0);
        step(1);
        check("t3_addr_inc", song_addr, 1);
        check("t3_dur_start", dur_start, 0);
        step(1);
        check("t4_dur_start", dur_start, 0);
        step(1);
        // Second note: rest
        check("n2_dur_start", dur_start, 1);
        check("n2_dur", dur, 8'h05);
        check("n2_pitch", pitch, 8'h00);
        check("n2_rest_note_en", note_en, 0);
        step(5);                                   // dur_done
        step(3);
        check("end_fetch_addr", song_addr, 2);
        step(2);
        check("end_pulse", song_end, 1);
        check("end_note_en", note_en, 0);
        check("end_playing", playing, 1);
        step(1);
        check("end_one_clk", song_end, 0);
        check("end_addr_zero", song_addr, 0);
        check("end_idle", playing, 0);
        step(1);
        check("loop_fetch", playing, 1);
        check("loop_addr", song_addr, 0);
        step(2);
        check("loop_dur_start", dur_start, 1);
        check("loop_dur", dur, 8'h0A);

        // Stop at 4th PLAY clock of addr 1, then resume
        step(10);
        step(3);
        check("b_addr1", song_addr, 1);
        step(2);
        check("b_dur_start", dur_start, 1);
        step(3);
        check("b_4th_play_clk", dur_start, 0);
        check("b_4th_playing", playing, 1);
        play = 1'b0;
        step(1);
        check("stop_idle", playing, 0);
        check("stop_note_en", note_en, 0);
        check("stop_dur_start", dur_start, 0);
        check("stop_addr_held", song_addr, 1);
        step(1);
        check("stop_addr_held2", song_addr, 1);
        play = 1'b1;
        step(1);
        check("resume_fetch", playing, 1);
        check("resume_addr", song_addr, 1);
        step(2);
        check("resume_dur_start", dur_start, 1);
        check("resume_dur", dur, 8'h05);

        // play=0 in the same clock as dur_done: address must not advance
        step(5);
        play = 1'b0;
        step(1);
        check("race_idle", playing, 0);
        check("race_addr", song_addr, 1);

        // Reset pulse during GAP
        play = 1'b1;
        step(3);
        check("g_dur_start", dur_start, 1);
        step(6);
        check("g_in_gap_playing", playing, 1);
        check("g_in_gap_note_en", note_en, 0);
        reset_n = 1'b0;
        step(1);
        check("grst_playing", playing, 0);
        check("grst_addr", song_addr, 0);
        check("grst_pitch", pitch, 0);
        check("grst_dur", dur, 0);
        check("grst_note_en", note_en, 0);
        check("grst_dur_start", dur_start, 0);
        check("grst_song_end", song_end, 0);
        reset_n = 1'b1;
        step(1);
        check("grel_fetch", playing, 1);
        check("grel_addr", song_addr, 0);
        step(2);
        check("grel_dur_start", dur_start, 1);
        check("grel_dur", dur, 8'h0A);

        // dur_done held high across the dur_start clock
        timer_auto = 1'b1;
        play = 1'b0;
        reset_n = 1'b0;
        step(1);
        timer_auto = 1'b0;
        manual_done = 1'b1;
        reset_n = 1'b1;
        play = 1'b1;
        step(3);
        check("hold_dur_start", dur_start, 1);
        step(1);
        check("hold_still_play", note_en, 1);
        check("hold_pulse_end", dur_start, 0);
        step(1);
        check("hold_gap_note_en", note_en, 0);
        check("hold_gap_playing", playing, 1);
        check("hold_gap_addr", song_addr, 0);
        step(2);
        check("hold_addr_inc", song_addr, 1);
        play = 1'b0;
        manual_done = 1'b0;
        timer_auto = 1'b1;
        step(1);

        // Wrap instance: addresses 0,1,2,3,0 four clocks apart, no song_end
        reset_n_b = 1'b1;
        play_b = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 12 && !found; w++) begin
                step(1);
                if (dur_start_b) found = 1'b1;
            end
            check("w_start_seen", {31'd0, found}, 1);
            check("w_addr", {30'd0, song_addr_b}, k % 4);
            if (k > 0) check("w_period", cyc - last_cyc, 4);
            last_cyc = cyc;
        end
        check("w_no_song_end", se_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, width of song memory address.
REQ-002 Parameter GAP_CYCLES, default 2, silent clocks inserted between consecutive notes (0 = none).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 play  input  1  level; 1 = run song, 0 = stop.
REQ-006 song_addr  output  ADDR_W  song memory read address.
REQ-007 song_data  input  16  memory word, valid exactly 1 clk after song_addr changes; [15:8] pitch, [7:0] duration.
REQ-008 pitch  output  8  registered pitch code to pwm.
REQ-009 note_en  output  1  pwm enable.
REQ-010 dur  output  8  registered duration to duration timer.
REQ-011 dur_start  output  1  one-clk pulse starting duration timer.
REQ-012 dur_done  input  1  duration timer completion, pulse or level.
REQ-013 playing  output  1  high in every state except IDLE.
REQ-014 song_end  output  1  one-clk pulse at end-of-song marker.

Function
REQ-015 States SHALL be IDLE, FETCH, LATCH, PLAY, GAP, END; encoding free.
REQ-016 IDLE: play=1 -> FETCH next clk; else stay; note_en=0, dur_start=0.
REQ-017 FETCH: hold song_addr for one clk -> LATCH.
REQ-018 LATCH: register pitch<=song_data[15:8], dur<=song_data[7:0]; if song_data[7:0]==0 -> END, else -> PLAY.
REQ-019 dur_start SHALL be 1 exactly on the first clk in PLAY, 0 otherwise.
REQ-020 PLAY: note_en=1 iff pitch!=0 (pitch 0 = rest, silent but timed).
REQ-021 PLAY SHALL ignore dur_done on the dur_start clk; from the next clk, dur_done=1 -> GAP (or, if GAP_CYCLES=0, increment song_addr and -> FETCH).
REQ-022 GAP: note_en=0; counter loaded with GAP_CYCLES on entry; stays exactly GAP_CYCLES clks, then song_addr<=song_addr+1 and -> FETCH.
REQ-023 song_addr increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0) without generating song_end.
REQ-024 END: song_end=1 for one clk, song_addr<=0, note_en=0, -> IDLE; if play still 1, IDLE re-enters FETCH next clk (loop).
REQ-025 play=0 in any state except IDLE SHALL force IDLE on next clk; note_en=0, dur_start=0, song_addr held (resume refetches current note from start of its duration).
REQ-026 play=0 and dur_done=1 in same clk: play wins, song_addr not incremented.
REQ-027 pitch and dur SHALL hold their values outside LATCH.
REQ-028 Note-to-note latency with dur_done pulse at clk t: next dur_start at t+GAP_CYCLES+3.

Reset
REQ-029 reset_n=0 at a clk edge SHALL set state IDLE, song_addr=0, pitch=0, dur=0, note_en=0, dur_start=0, playing=0, song_end=0, gap counter=0, regardless of state or play.
REQ-030 Reset SHALL take priority over all other inputs, including mid-PLAY and mid-GAP.

Verification
REQ-031 Two-note song {0x3C0A, 0x0005, 0x0000}, play=1, timer model asserts dur_done dur clks after dur_start -> dur_start with dur=10 note_en=1, then dur=5 note_en=0 (rest), song_end pulse, song_addr=0, replay begins.
REQ-032 GAP_CYCLES=2, dur_done at clk t -> note_en=0 on t+1..t+2, song_addr+1 at t+3 edge, next dur_start at t+5.
REQ-033 ADDR_W=2, memory all 0x4001 -> song_addr sequence 0,1,2,3,0 with no song_end.
REQ-034 play dropped at 4th clk of PLAY at addr 1 -> IDLE next clk, note_en=0, song_addr=1; play reasserted -> refetches addr 1, dur_start pulses again.
REQ-035 reset_n=0 one clk during GAP -> all outputs 0, song_addr=0, state IDLE; with play=1 FETCH addr 0 follows release.
REQ-036 dur_done held high during dur_start clk -> ignored that clk, GAP entered next clk.
